// File: rtl/candle_game_engine.sv
// Candle/match game core: debounced move button, signed multi-step moves,
// wrap or clamp edges, saturating move counter and sticky win.
module candle_game_engine #(
    parameter int               N_POS        = 8,
    parameter int               MOVE_W       = 4,
    parameter logic [N_POS-1:0] INIT_CANDLES = N_POS'(8'b1010_0100),
    parameter int               MATCH_INIT   = 0,
    parameter bit               WRAP         = 1'b1,
    parameter int               DB_CYCLES    = 16,
    parameter int               STEP_CYCLES  = 4,
    parameter int               CNT_W        = 8
) (
    input  logic                     CLK100MHZ,
    input  logic                     BTNR,
    input  logic                     BTNC,
    input  logic [MOVE_W-1:0]        SW,
    output logic [N_POS-1:0]         LED,
    output logic [N_POS-1:0]         candles_lit,
    output logic [$clog2(N_POS)-1:0] match_pos,
    output logic                     busy,
    output logic                     extinguish,
    output logic                     win,
    output logic [CNT_W-1:0]         move_count
);
    localparam int POS_W = $clog2(N_POS);
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int SC_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_POS - 1);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(MATCH_INIT);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DB_CYCLES);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STEP_CYCLES - 1);

    if (INIT_CANDLES[MATCH_INIT] != 1'b0) begin : g_init_check
        $error("INIT_CANDLES has a candle under MATCH_INIT");
    end

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, WIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sync0;
    logic               sync1;
    logic [DB_W-1:0]    db_cnt;
    logic               accept;
    logic               dir;
    logic [MOVE_W-1:0]  rem;
    logic [SC_W-1:0]    step_cnt;
    logic               at_edge;
    logic               blocked;
    logic [POS_W-1:0]   pos_step;

    // Counter saturates at DB_FULL so one high period yields one acceptance
    always_ff @(posedge CLK100MHZ or posedge BTNR) begin
        if (BTNR) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync0 <= BTNC;
            sync1 <= sync0;
            if (!sync1)
                db_cnt <= '0;
            else if (db_cnt != DB_FULL)
                db_cnt <= db_cnt + 1'b1;
        end
    end

    assign accept = sync1 && (db_cnt == DB_LAST);

    assign at_edge = dir ? (match_pos == '0) : (match_pos == POS_MAX);
    assign blocked = !WRAP && at_edge;

    always_comb begin
        pos_step = match_pos;
        if (dir)
            pos_step = at_edge ? POS_MAX : match_pos - 1'b1;
        else
            pos_step = at_edge ? '0 : match_pos + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or posedge BTNR) begin
        if (BTNR)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = MOVE;
            MOVE:  if (rem == '0) state_nxt = CHECK;
            CHECK: state_nxt = (candles_lit == '0) ? WIN : IDLE;
            WIN:   state_nxt = WIN;
            default: state_nxt = IDLE;
        endcase
    end

    // The landing candle is cleared on entry to CHECK so that extinguish
    // and the updated mask are both visible during the CHECK cycle.
    always_ff @(posedge CLK100MHZ or posedge BTNR) begin
        if (BTNR) begin
            match_pos   <= POS_INIT;
            candles_lit <= INIT_CANDLES;
            move_count  <= '0;
            dir         <= 1'b0;
            rem         <= '0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            extinguish  <= 1'b0;
            win         <= 1'b0;
        end else begin
            extinguish <= 1'b0;
            busy       <= (state_nxt == MOVE) || (state_nxt == CHECK);
            win        <= (state_nxt == WIN);
            if (state == IDLE && accept) begin
                dir      <= SW[MOVE_W-1];
                rem      <= SW[MOVE_W-1] ? (~SW + 1'b1) : SW;
                step_cnt <= '0;
                if (move_count != '1)
                    move_count <= move_count + 1'b1;
            end
            if (state == MOVE && rem != '0) begin
                if (step_cnt == SC_LAST) begin
                    step_cnt <= '0;
                    if (blocked) begin
                        rem <= '0;
                    end else begin
                        match_pos <= pos_step;
                        rem       <= rem - 1'b1;
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
            if (state == MOVE && rem == '0) begin
                extinguish             <= candles_lit[match_pos];
                candles_lit[match_pos] <= 1'b0;
            end
        end
    end

    assign LED = candles_lit | ({{(N_POS-1){1'b0}}, 1'b1} << match_pos);

endmodule

// File: tb/tb_candle_game_engine.sv
// Directed bench for candle_game_engine: a wrapping and a clamping
// instance share inputs; per-move table plus multi-cycle sequences.
module tb_candle_game_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [3:0] sw;

    logic [7:0] led1, cl1, led0, cl0;
    logic [2:0] pos1, pos0;
    logic       busy1, ext1, win1, busy0, ext0, win0;
    logic [7:0] cnt1, cnt0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int e1, e0, b1;
    logic [2:0] prev1;
    int chg[$];

    always #5 clk = ~clk;

    candle_game_engine #(.WRAP(1'b1)) dut_wrap (
        .CLK100MHZ(clk), .BTNR(rst), .BTNC(btn), .SW(sw),
        .LED(led1), .candles_lit(cl1), .match_pos(pos1), .busy(busy1),
        .extinguish(ext1), .win(win1), .move_count(cnt1)
    );

    candle_game_engine #(.WRAP(1'b0)) dut_clamp (
        .CLK100MHZ(clk), .BTNR(rst), .BTNC(btn), .SW(sw),
        .LED(led0), .candles_lit(cl0), .match_pos(pos0), .busy(busy0),
        .extinguish(ext0), .win(win0), .move_count(cnt0)
    );

    typedef struct {
        logic [3:0] sw;
        int         hold;
        int         pos1, cl1, cnt1, win1, ext1, busy1;
        int         pos0, cl0, cnt0, win0, ext0;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ext1) e1++;
        if (ext0) e0++;
        if (busy1) b1++;
        if (pos1 != prev1) chg.push_back(cyc);
        prev1 = pos1;
    endtask

    task automatic clear_mon();
        e1 = 0;
        e0 = 0;
        b1 = 0;
        chg.delete();
    endtask

    task automatic do_reset();
        btn = 1'b0;
        sw  = 4'd0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        prev1 = 3'd0;
        tick();
        clear_mon();
    endtask

    task automatic press(input logic [3:0] s, input int hold);
        clear_mon();
        sw  = s;
        btn = 1'b1;
        repeat (hold) tick();
        btn = 1'b0;
        repeat (80) tick();
    endtask

    function automatic int led_of(input int cl, input int pos);
        return cl | (1 << pos);
    endfunction

    initial begin
        // sw hold | wrap: pos cl cnt win ext busy | clamp: pos cl cnt win ext
        vecs[0] = '{4'd0, 100, 0, 'hA4, 1, 0, 0, 2,  0, 'hA4, 1, 0, 0};
        vecs[1] = '{4'd2, 25,  2, 'hA0, 2, 0, 1, 10, 2, 'hA0, 2, 0, 1};
        vecs[2] = '{4'd3, 25,  5, 'h80, 3, 0, 1, 14, 5, 'h80, 3, 0, 1};
        vecs[3] = '{4'hF, 25,  4, 'h80, 4, 0, 0, 6,  4, 'h80, 4, 0, 0};
        vecs[4] = '{4'd7, 25,  3, 'h80, 5, 0, 0, 30, 7, 'h00, 5, 1, 1};
        vecs[5] = '{4'h8, 25,  3, 'h80, 6, 0, 0, 34, 7, 'h00, 5, 1, 0};
        vecs[6] = '{4'd4, 25,  7, 'h00, 7, 1, 1, 18, 7, 'h00, 5, 1, 0};
        vecs[7] = '{4'd1, 25,  7, 'h00, 7, 1, 0, 0,  7, 'h00, 5, 1, 0};

        do_reset();
        chk("rst_led", led1, 'hA5);
        chk("rst_pos", pos1, 0);
        chk("rst_win", win1, 0);
        chk("rst_cnt", cnt1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ext", ext1, 0);
        chk("rst_led_clamp", led0, 'hA5);

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].sw, vecs[i].hold);
            chk($sformatf("v%0d_pos", i), pos1, vecs[i].pos1);
            chk($sformatf("v%0d_cl", i), cl1, vecs[i].cl1);
            chk($sformatf("v%0d_led", i), led1, led_of(vecs[i].cl1, vecs[i].pos1));
            chk($sformatf("v%0d_cnt", i), cnt1, vecs[i].cnt1);
            chk($sformatf("v%0d_win", i), win1, vecs[i].win1);
            chk($sformatf("v%0d_ext", i), e1, vecs[i].ext1);
            chk($sformatf("v%0d_busy", i), b1, vecs[i].busy1);
            chk($sformatf("v%0d_busy_end", i), busy1, 0);
            chk($sformatf("v%0d_pos_clamp", i), pos0, vecs[i].pos0);
            chk($sformatf("v%0d_cl_clamp", i), cl0, vecs[i].cl0);
            chk($sformatf("v%0d_cnt_clamp", i), cnt0, vecs[i].cnt0);
            chk($sformatf("v%0d_win_clamp", i), win0, vecs[i].win0);
            chk($sformatf("v%0d_ext_clamp", i), e0, vecs[i].ext0);
        end

        // two-step move: positions change one STEP_CYCLES apart
        do_reset();
        press(4'd2, 25);
        chk("step_changes", chg.size(), 2);
        if (chg.size() == 2)
            chk("step_spacing", chg[1] - chg[0], 4);
        chk("step_ext", e1, 1);
        chk("step_cl", cl1, 'hA0);

        // -1 from position 0: wraps to 7 or is blocked at 0
        do_reset();
        press(4'hF, 25);
        chk("neg1_pos", pos1, 7);
        chk("neg1_cl", cl1, 'h24);
        chk("neg1_ext", e1, 1);
        chk("neg1_pos_clamp", pos0, 0);
        chk("neg1_cl_clamp", cl0, 'hA4);
        chk("neg1_ext_clamp", e0, 0);
        chk("neg1_cnt_clamp", cnt0, 1);

        // short glitch, then a second press during a long move
        do_reset();
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        repeat (30) tick();
        chk("glitch_cnt", cnt1, 0);
        chk("glitch_pos", pos1, 0);
        chk("glitch_busy", b1, 0);
        clear_mon();
        sw  = 4'd7;
        btn = 1'b1;
        repeat (22) tick();
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        repeat (50) tick();
        btn = 1'b0;
        repeat (40) tick();
        chk("dbl_cnt", cnt1, 1);
        chk("dbl_pos", pos1, 7);
        chk("dbl_cl", cl1, 'h24);
        chk("dbl_ext", e1, 1);
        chk("dbl_busy", b1, 30);

        // asynchronous reset in the middle of a move
        do_reset();
        sw  = 4'd3;
        btn = 1'b1;
        begin
            int k;
            for (k = 0; k < 60 && !busy1; k++) tick();
            chk("mid_busy_seen", busy1, 1);
        end
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("mid_pos", pos1, 0);
        chk("mid_cl", cl1, 'hA4);
        chk("mid_led", led1, 'hA5);
        chk("mid_cnt", cnt1, 0);
        chk("mid_busy", busy1, 0);
        chk("mid_ext", ext1, 0);
        chk("mid_win", win1, 0);
        btn = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_after_pos", pos1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
